// File: rtl/haz_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package haz_pkg;

    localparam int unsigned REGW_DEF = 5;
    localparam int unsigned CNTW     = 4;

    // E-stage operand source select
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Multiply/divide unit occupancy
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/haz_mdu_tracker.sv
// Tracks multiply/divide unit occupancy: busy for MDU_LAT cycles after an issue.
module haz_mdu_tracker
    import haz_pkg::*;
#(
    parameter int unsigned MDU_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic mdustartE,
    output logic mdubusy
);

    mdu_state_t        state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    // State and counter registers; reset abandons any in-flight op
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: load on issue from idle, count down while busy, ignore issues while busy
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mdustartE) begin
                    state_d = BUSY;
                    cnt_d   = CNTW'(MDU_LAT - 1);
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign mdubusy = (state_q == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load/branch/MDU stalls.
// Optional performance counters (stallcnt, mdustallcnt) when HAZ_PERF_EN is defined.
module hazard_ctrl
    import haz_pkg::*;
#(
    parameter int unsigned REGW    = REGW_DEF,
    parameter int unsigned MDU_LAT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            branchD,
    input  logic            mduopD,
    input  logic [REGW-1:0] rsD,
    input  logic [REGW-1:0] rtD,
    input  logic [REGW-1:0] rsE,
    input  logic [REGW-1:0] rtE,
    input  logic [REGW-1:0] writeregE,
    input  logic [REGW-1:0] writeregM,
    input  logic [REGW-1:0] writeregW,
    input  logic            regwriteE,
    input  logic            regwriteM,
    input  logic            regwriteW,
    input  logic            memtoregE,
    input  logic            memtoregM,
    input  logic            mdustartE,
    output logic            stallF,
    output logic            stallD,
    output logic            flushE,
    output logic            forwardAD,
    output logic            forwardBD,
    output logic [1:0]      forwardAE,
    output logic [1:0]      forwardBE,
    output logic            mdubusy
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]     stallcnt,
    output logic [31:0]     mdustallcnt
`endif
);

    logic lwstall, branchstall, mdustall, stall;
    fwd_sel_t fwd_a, fwd_b;

    // M stage wins over W; register 0 is never forwarded
    function automatic fwd_sel_t sel_e(
        input logic [REGW-1:0] src,
        input logic [REGW-1:0] wm,
        input logic            rwm,
        input logic [REGW-1:0] ww,
        input logic            rww
    );
        if (src != '0 && src == wm && rwm) begin
            return FWD_MEM;
        end else if (src != '0 && src == ww && rww) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    // E-stage operand forwarding
    always_comb begin
        fwd_a = sel_e(rsE, writeregM, regwriteM, writeregW, regwriteW);
        fwd_b = sel_e(rtE, writeregM, regwriteM, writeregW, regwriteW);
    end

    assign forwardAE = fwd_a;
    assign forwardBE = fwd_b;

    // D-stage branch-compare forwarding from M
    assign forwardAD = (rsD != '0) && (rsD == writeregM) && regwriteM;
    assign forwardBD = (rtD != '0) && (rtD == writeregM) && regwriteM;

    haz_mdu_tracker #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu (
        .clk       (clk),
        .reset     (reset),
        .mdustartE (mdustartE),
        .mdubusy   (mdubusy)
    );

    // Stall sources; a non-load M result reaches the branch via forwarding
    always_comb begin
        lwstall     = memtoregE && (rtE != '0) && ((rsD == rtE) || (rtD == rtE));
        branchstall = branchD &&
                      ((regwriteE && (writeregE != '0) &&
                        ((writeregE == rsD) || (writeregE == rtD))) ||
                       (memtoregM && (writeregM != '0) &&
                        ((writeregM == rsD) || (writeregM == rtD))));
        mdustall    = mduopD && (mdubusy || mdustartE);
        stall       = !reset && (lwstall || branchstall || mdustall);
    end

    assign stallF = stall;
    assign stallD = stall;
    assign flushE = stall;

`ifdef HAZ_PERF_EN
    logic [31:0] stallcnt_q, stallcnt_d;
    logic [31:0] mdustallcnt_q, mdustallcnt_d;

    // Saturating event counters
    always_comb begin
        stallcnt_d    = stallcnt_q;
        mdustallcnt_d = mdustallcnt_q;
        if (stall && stallcnt_q != 32'hFFFF_FFFF) begin
            stallcnt_d = stallcnt_q + 32'd1;
        end
        if (mdustall && mdustallcnt_q != 32'hFFFF_FFFF) begin
            mdustallcnt_d = mdustallcnt_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stallcnt_q    <= '0;
            mdustallcnt_q <= '0;
        end else begin
            stallcnt_q    <= stallcnt_d;
            mdustallcnt_q <= mdustallcnt_d;
        end
    end

    assign stallcnt    = stallcnt_q;
    assign mdustallcnt = mdustallcnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized self-checking bench for hazard_ctrl against a behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned REGW    = 5;
    localparam int unsigned MDU_LAT = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            branchD, mduopD;
    logic [REGW-1:0] rsD, rtD, rsE, rtE;
    logic [REGW-1:0] writeregE, writeregM, writeregW;
    logic            regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic            mdustartE;
    logic            stallF, stallD, flushE, forwardAD, forwardBD, mdubusy;
    logic [1:0]      forwardAE, forwardBE;
`ifdef HAZ_PERF_EN
    logic [31:0]     stallcnt, mdustallcnt;
    longint          m_scnt, m_mcnt;
`endif

    int checks = 0;
    int errors = 0;
    int rem    = 0;   // model: remaining busy cycles of the MDU

    hazard_ctrl #(.REGW(REGW), .MDU_LAT(MDU_LAT)) dut (
        .clk(clk), .reset(reset), .branchD(branchD), .mduopD(mduopD),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .mdustartE(mdustartE),
        .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .mdubusy(mdubusy)
`ifdef HAZ_PERF_EN
        , .stallcnt(stallcnt), .mdustallcnt(mdustallcnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int m_fwd_e(input int src);
        if (src == 0) return 0;
        if (regwriteM && int'(writeregM) == src) return 2;
        if (regwriteW && int'(writeregW) == src) return 1;
        return 0;
    endfunction

    function automatic bit m_mdustall();
        return mduopD && (rem > 0 || mdustartE);
    endfunction

    function automatic bit m_stall();
        bit lw, br, hitE, hitM;
        lw   = memtoregE && rtE != 0 && (rsD == rtE || rtD == rtE);
        hitE = regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD);
        hitM = memtoregM && writeregM != 0 && (writeregM == rsD || writeregM == rtD);
        br   = branchD && (hitE || hitM);
        return !reset && (lw || br || m_mdustall());
    endfunction

    // Compare every output against the model
    task automatic compare_all();
        bit s;
        s = m_stall();
        chk("stallF", 32'(stallF), 32'(s));
        chk("stallD", 32'(stallD), 32'(s));
        chk("flushE", 32'(flushE), 32'(s));
        chk("forwardAE", 32'(forwardAE), 32'(m_fwd_e(int'(rsE))));
        chk("forwardBE", 32'(forwardBE), 32'(m_fwd_e(int'(rtE))));
        chk("forwardAD", 32'(forwardAD), 32'(rsD != 0 && rsD == writeregM && regwriteM));
        chk("forwardBD", 32'(forwardBD), 32'(rtD != 0 && rtD == writeregM && regwriteM));
        chk("mdubusy", 32'(mdubusy), 32'(rem > 0));
`ifdef HAZ_PERF_EN
        chk("stallcnt", stallcnt, 32'(m_scnt));
        chk("mdustallcnt", mdustallcnt, 32'(m_mcnt));
`endif
    endtask

    // Advance one clock, updating the model with the inputs seen at the edge
    task automatic step();
        bit s, ms;
        s  = m_stall();
        ms = m_mdustall();
        @(posedge clk);
        if (reset) begin
            rem = 0;
        end else if (rem > 0) begin
            rem = rem - 1;
        end else if (mdustartE) begin
            rem = MDU_LAT;
        end
`ifdef HAZ_PERF_EN
        if (reset) begin
            m_scnt = 0;
            m_mcnt = 0;
        end else begin
            if (s && m_scnt < 64'hFFFF_FFFF) m_scnt++;
            if (ms && m_mcnt < 64'hFFFF_FFFF) m_mcnt++;
        end
`endif
        #1;
    endtask

    task automatic zero_in();
        reset = 0; branchD = 0; mduopD = 0; mdustartE = 0;
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0; memtoregE = 0; memtoregM = 0;
    endtask

    task automatic rand_in();
        reset     = ($urandom_range(0, 39) == 0);
        branchD   = 1'($urandom_range(0, 1));
        mduopD    = 1'($urandom_range(0, 1));
        mdustartE = ($urandom_range(0, 5) == 0);
        rsD = REGW'($urandom_range(0, 3)); rtD = REGW'($urandom_range(0, 3));
        rsE = REGW'($urandom_range(0, 3)); rtE = REGW'($urandom_range(0, 3));
        writeregE = REGW'($urandom_range(0, 3));
        writeregM = REGW'($urandom_range(0, 3));
        writeregW = REGW'($urandom_range(0, 3));
        regwriteE = 1'($urandom_range(0, 1)); regwriteM = 1'($urandom_range(0, 1));
        regwriteW = 1'($urandom_range(0, 1)); memtoregE = 1'($urandom_range(0, 1));
        memtoregM = 1'($urandom_range(0, 1));
    endtask

    initial begin
`ifdef HAZ_PERF_EN
        m_scnt = 0;
        m_mcnt = 0;
`endif
        zero_in();
        // Reset cycle with a load-use hazard present: stalls must be masked
        reset = 1; memtoregE = 1; rtE = 5; rsD = 5;
        #1;
        chk("reset_mask_stall", 32'(stallF), 32'd0);
        step();
        chk("reset_mdubusy", 32'(mdubusy), 32'd0);
        zero_in();

        // E-stage forwarding priority
        rsE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1; #1;
        chk("fwdAE_mem", 32'(forwardAE), 32'h2); compare_all();
        regwriteM = 0; #1;
        chk("fwdAE_wb", 32'(forwardAE), 32'h1); compare_all();
        rsE = 0; #1;
        chk("fwdAE_zero", 32'(forwardAE), 32'h0); compare_all();
        zero_in();

        // Load-use stall
        memtoregE = 1; rtE = 5; rsD = 5; #1;
        chk("lw_stall", 32'({stallF, stallD, flushE}), 32'h7); compare_all();
        rtE = 0; #1;
        chk("lw_r0", 32'({stallF, stallD, flushE}), 32'h0); compare_all();
        zero_in();

        // Branch compare: ALU result in M forwarded, load in M stalls
        branchD = 1; rsD = 7; writeregM = 7; regwriteM = 1; #1;
        chk("br_fwd_nostall", 32'({stallF, forwardAD}), 32'h1); compare_all();
        memtoregM = 1; #1;
        chk("br_load_stall", 32'(stallF), 32'd1); compare_all();
        zero_in();
        step();

        // MDU occupancy: issue then four busy cycles, stalling a waiting MDU op
        mduopD = 1; mdustartE = 1; #1;
        chk("mdu_issue_stall", 32'({mdubusy, stallF}), 32'h1);
        step();
        mdustartE = 0;
        for (int i = 0; i < 4; i++) begin
            chk("mdu_busy_stall", 32'({mdubusy, stallF}), 32'h3);
            compare_all();
            step();
        end
        chk("mdu_done", 32'({mdubusy, stallF}), 32'h0); compare_all();
        step();

        // Reset while busy abandons the op
        mdustartE = 1; step();
        mdustartE = 0; step();
        reset = 1; #1;
        chk("rst_busy_stall", 32'({mdubusy, stallF}), 32'h2); compare_all();
        step();
        reset = 0; #1;
        chk("rst_busy_clr", 32'(mdubusy), 32'd0); compare_all();
        zero_in();
        step();

`ifdef HAZ_PERF_EN
        // Saturation of the stall counter
        force dut.stallcnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stallcnt_q;
        m_scnt = 64'hFFFF_FFFE;
        memtoregE = 1; rtE = 5; rsD = 5;
        for (int i = 0; i < 3; i++) step();
        chk("stallcnt_sat", stallcnt, 32'hFFFF_FFFF); compare_all();
        reset = 1; step();
        zero_in();
`endif

        // Randomized traffic checked every cycle
        for (int i = 0; i < 800; i++) begin
            rand_in();
            #1;
            compare_all();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REGW, default 5: register-index width.
REQ-002 Parameter MDU_LAT, default 4: multiply/divide unit busy cycles; legal range 1..15.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 branchD, mduopD  in  1 each  D-stage instruction is a branch / is an MDU op (mult, div, mfhi, mflo).
REQ-006 rsD, rtD, rsE, rtE  in  REGW each  source register indices.
REQ-007 writeregE, writeregM, writeregW  in  REGW each  destination indices.
REQ-008 regwriteE, regwriteM, regwriteW, memtoregE, memtoregM  in  1 each  stage write-enable / load flags.
REQ-009 mdustartE  in  1  an MDU op issues from E this cycle.
REQ-010 stallF, stallD, flushE  out  1 each  pipeline control.
REQ-011 forwardAD, forwardBD  out  1 each  D-stage compare forward from M.
REQ-012 forwardAE, forwardBE  out  2 each  E-stage operand select.
REQ-013 mdubusy  out  1  MDU result not yet available.

Function
REQ-014 forwardAE SHALL be 2'b10 when rsE!=0 & rsE==writeregM & regwriteM, else 2'b01 when rsE!=0 & rsE==writeregW & regwriteW, else 2'b00; M takes priority over W.
REQ-015 forwardBE SHALL follow REQ-014 with rtE substituted for rsE.
REQ-016 forwardAD = rsD!=0 & rsD==writeregM & regwriteM; forwardBD is the same with rtD.
REQ-017 lwstall = memtoregE & rtE!=0 & (rsD==rtE | rtD==rtE).
REQ-018 branchstall = branchD & ((regwriteE & writeregE!=0 & writeregE matches rsD or rtD) | (memtoregM & writeregM!=0 & writeregM matches rsD or rtD)); a non-load M result is forwarded and SHALL NOT stall.
REQ-019 The MDU tracker SHALL be an FSM with states IDLE and BUSY plus a 4-bit down-counter.
REQ-020 In IDLE with mdustartE=1: next state BUSY, counter loaded with MDU_LAT-1.
REQ-021 In BUSY: counter decrements each cycle; when counter==0, next state IDLE.
REQ-022 mdubusy = (state==BUSY); an issue in cycle t SHALL give mdubusy high in cycles t+1 through t+MDU_LAT inclusive.
REQ-023 mdustartE in BUSY SHALL be ignored; the state and counter are unchanged.
REQ-024 mdustall = mduopD & (mdubusy | mdustartE).
REQ-025 stall = lwstall | branchstall | mdustall; stallF = stallD = flushE = stall.
REQ-026 All outputs except mdubusy SHALL be combinational with zero latency; mdubusy is registered state.

Reset
REQ-027 While reset=1, stallF, stallD and flushE SHALL be forced to 0 in the same cycle.
REQ-028 On a rising edge with reset=1: state goes to IDLE, the counter to 0 and mdubusy to 0; an in-flight MDU op is abandoned.
REQ-029 Forward outputs SHALL remain purely combinational and are not gated by reset.

Configuration
REQ-030 With macro HAZ_PERF_EN defined, output ports stallcnt (32 bit) and mdustallcnt (32 bit) SHALL exist.
REQ-031 Under HAZ_PERF_EN, stallcnt increments each cycle stall=1 and mdustallcnt increments each cycle mdustall=1.
REQ-032 Under HAZ_PERF_EN, both counters saturate at 32'hFFFF_FFFF and are cleared by reset.
REQ-033 Without HAZ_PERF_EN, neither port nor its logic SHALL exist; all other behaviour is identical.

Structure
REQ-034 Package haz_pkg SHALL hold fwd_sel_t (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10), mdu_state_t {IDLE, BUSY} and the default REGW.
REQ-035 The FSM and counter SHALL live in sub-module haz_mdu_tracker (ports clk, reset, mdustartE, mdubusy).

Verification
REQ-036 rsE=3, writeregM=3, regwriteM=1, writeregW=3, regwriteW=1 -> forwardAE=2'b10; with regwriteM=0 -> 2'b01; with rsE=0 -> 2'b00.
REQ-037 memtoregE=1, rtE=5, rsD=5 -> stallF=stallD=flushE=1; with rtE=0 -> all 0.
REQ-038 branchD=1, rsD=7, writeregM=7, regwriteM=1, memtoregM=0 -> no stall and forwardAD=1; with memtoregM=1 -> stall=1.
REQ-039 MDU_LAT=4, mdustartE pulse at cycle 10 -> mdubusy high in cycles 11-14; mduopD=1 throughout -> stall in cycles 10-14, none at 15.
REQ-040 reset asserted at cycle 12 of REQ-039 -> stall=0 in cycle 12 and mdubusy=0 from cycle 13.
REQ-041 With HAZ_PERF_EN, counter preloaded to 32'hFFFF_FFFE via force and 3 stall cycles -> reads 32'hFFFF_FFFF.
